// File: rtl/turkey_sensor_emulator_pkg.sv
// Shared encodings for the turkey sensor emulator: one-hot phase states,
// sensor line patterns and the direction convention.
package turkey_sensor_emulator_pkg;

    // One-hot phase encoding, same style as the crossing detector.
    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_ENTER = 5'b00010,
        ST_BOTH  = 5'b00100,
        ST_EXIT  = 5'b01000,
        ST_GAP   = 5'b10000
    } state_t;

    // Sensor pair as {LS, RS}: 1 = beam clear, 0 = beam blocked.
    localparam logic [1:0] SNS_CLEAR = 2'b11;
    localparam logic [1:0] SNS_BOTH  = 2'b00;

    // dir value for a left-to-right walk.
    localparam logic DIR_RIGHT = 1'b1;

    // {LS, RS} for a phase. Patterns are written for a left-to-right walk
    // and mirrored for right-to-left.
    function automatic logic [1:0] sensor_pattern(state_t st, logic dir);
        logic [1:0] p;
        p = SNS_CLEAR;
        case (st)
            ST_ENTER: p = 2'b01;
            ST_BOTH:  p = SNS_BOTH;
            ST_EXIT:  p = 2'b10;
            default:  p = SNS_CLEAR;
        endcase
        return (dir == DIR_RIGHT) ? p : {p[0], p[1]};
    endfunction

endpackage

// File: rtl/turkey_sensor_emulator_if.sv
// Command/status bundle between the button logic (master) and the
// emulator (slave). LS/RS feed the crossing detector.
interface turkey_sensor_emulator_if #(
    parameter int DWELL_W = 16,
    parameter int CNT_W   = 8
);
    logic               start;
    logic               dir;
    logic               backout;
    logic [DWELL_W-1:0] dwell;
    logic               LS;
    logic               RS;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   right_count;
    logic [CNT_W-1:0]   left_count;

    modport master (
        output start, dir, backout, dwell,
        input  LS, RS, busy, done, right_count, left_count
    );

    modport slave (
        input  start, dir, backout, dwell,
        output LS, RS, busy, done, right_count, left_count
    );
endinterface

// File: rtl/turkey_sensor_emulator_phase_timer.sv
// Loadable down-counter timing one sensor phase. expire is high while the
// count sits at zero, so a load of N gives N+1 cycles before the phase ends.
module turkey_sensor_emulator_phase_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    output logic               expire
);
    logic [DWELL_W-1:0] count;

    // Load on phase entry, otherwise count down and hold at zero.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - DWELL_W'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/turkey_sensor_emulator.sv
// Turkey sensor emulator: plays one gate crossing (left-to-right,
// right-to-left or back-out) onto LS/RS and counts completed crossings.
module turkey_sensor_emulator
    import turkey_sensor_emulator_pkg::*;
#(
    parameter int DWELL_W = 16,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    turkey_sensor_emulator_if.slave bus
);
    state_t             state;
    state_t             state_next;
    logic               dir_q;
    logic               backout_q;
    logic [DWELL_W-1:0] dwell_m1_q;   // D-1 of the crossing in flight
    logic [DWELL_W-1:0] dwell_m1_in;  // D-1 from the live dwell input
    logic [DWELL_W-1:0] load_val;
    logic               accept;
    logic               expire;
    logic               load;
    logic               dir_next;
    logic               crossing_end;
    logic [1:0]         sns_next;

    assign accept       = (state == ST_IDLE) && bus.start;
    // dwell of 0 behaves as 1, so the phase timer load is max(dwell,1)-1.
    assign dwell_m1_in  = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);
    // On the accept edge the latched copies are not valid yet.
    assign load_val     = accept ? dwell_m1_in : dwell_m1_q;
    assign dir_next     = accept ? bus.dir : dir_q;
    assign load         = (state_next != state);
    assign crossing_end = (state == ST_GAP) && expire;
    assign sns_next     = sensor_pattern(state_next, dir_next);
    assign bus.busy     = (state != ST_IDLE);

    turkey_sensor_emulator_phase_timer #(
        .DWELL_W (DWELL_W)
    ) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    // Phase sequencing: each non-idle phase lasts until the timer expires.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            ST_IDLE:  if (bus.start) state_next = ST_ENTER;
            ST_ENTER: if (expire)    state_next = backout_q ? ST_GAP : ST_BOTH;
            ST_BOTH:  if (expire)    state_next = ST_EXIT;
            ST_EXIT:  if (expire)    state_next = ST_GAP;
            ST_GAP:   if (expire)    state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // State, latched crossing parameters and sensor flops from next-state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            dir_q      <= DIR_RIGHT;
            backout_q  <= 1'b0;
            dwell_m1_q <= '0;
            bus.LS     <= 1'b1;
            bus.RS     <= 1'b1;
        end else begin
            state <= state_next;
            if (accept) begin
                dir_q      <= bus.dir;
                backout_q  <= bus.backout;
                dwell_m1_q <= dwell_m1_in;
            end
            {bus.LS, bus.RS} <= sns_next;
        end
    end

    // Completion pulse and crossing counters; back-outs are never counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.done        <= 1'b0;
            bus.right_count <= '0;
            bus.left_count  <= '0;
        end else begin
            bus.done <= crossing_end;
            if (crossing_end && !backout_q) begin
                if (dir_q == DIR_RIGHT) begin
                    bus.right_count <= bus.right_count + CNT_W'(1);
                end else begin
                    bus.left_count <= bus.left_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_turkey_sensor_emulator.sv
// Directed self-checking bench for turkey_sensor_emulator.
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_turkey_sensor_emulator;

    localparam int DWELL_W = 16;
    localparam int CNT_W   = 8;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   mdl_right;
    int   mdl_left;

    turkey_sensor_emulator_if #(.DWELL_W(DWELL_W), .CNT_W(CNT_W)) bus ();

    turkey_sensor_emulator #(
        .DWELL_W (DWELL_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {LS,RS} in cycle c (1-based) of a crossing with dwell d.
    function automatic logic [1:0] exp_sns(int c, int d, bit dir_r, bit bo);
        int         ph;
        logic [1:0] p;
        ph = (c - 1) / d;
        if (bo && ph == 1) ph = 3;
        case (ph)
            0:       p = 2'b01;
            1:       p = 2'b00;
            2:       p = 2'b10;
            default: p = 2'b11;
        endcase
        if (!dir_r) p = {p[0], p[1]};
        return p;
    endfunction

    task automatic test_reset();
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.dir     = 1'b1;
        bus.backout = 1'b0;
        bus.dwell   = '0;
        mdl_right   = 0;
        mdl_left    = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.LS, bus.RS, bus.busy, bus.done} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 1100", {bus.LS, bus.RS, bus.busy, bus.done});
        end
        checks++;
        if ({bus.right_count, bus.left_count} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_counts: got %h want 0000", {bus.right_count, bus.left_count});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.LS, bus.RS, bus.busy, bus.done} !== 4'b1100) begin
            errors++;
            $display("FAIL idle_after_reset: got %b want 1100", {bus.LS, bus.RS, bus.busy, bus.done});
        end
    endtask

    // One crossing with cycle-by-cycle pattern checks. With perturb set the
    // command inputs are changed one cycle after accept; the crossing must
    // keep its latched values.
    task automatic test_single_crossing(input string name, input bit d_dir, input bit bo,
                                        input int dw, input bit perturb);
        int d;
        int len;
        d   = (dw == 0) ? 1 : dw;
        len = bo ? 2 * d : 4 * d;
        bus.start   = 1'b1;
        bus.dir     = d_dir;
        bus.backout = bo;
        bus.dwell   = DWELL_W'(dw);
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= len; c++) begin
            checks++;
            if ({bus.LS, bus.RS, bus.busy, bus.done} !== {exp_sns(c, d, d_dir, bo), 2'b10}) begin
                errors++;
                $display("FAIL %s_cycle%0d: got %b want %b", name, c,
                         {bus.LS, bus.RS, bus.busy, bus.done}, {exp_sns(c, d, d_dir, bo), 2'b10});
            end
            if (perturb && c == 1) begin
                bus.dir     = ~d_dir;
                bus.backout = ~bo;
                bus.dwell   = DWELL_W'(7);
            end
            @(negedge clk);
        end
        checks++;
        if ({bus.LS, bus.RS, bus.busy, bus.done} !== 4'b1101) begin
            errors++;
            $display("FAIL %s_done: got %b want 1101", name, {bus.LS, bus.RS, bus.busy, bus.done});
        end
        if (!bo) begin
            if (d_dir) mdl_right++;
            else       mdl_left++;
        end
        checks++;
        if ({bus.right_count, bus.left_count} !== {CNT_W'(mdl_right), CNT_W'(mdl_left)}) begin
            errors++;
            $display("FAIL %s_counts: got %0d/%0d want %0d/%0d", name, bus.right_count,
                     bus.left_count, mdl_right % 256, mdl_left % 256);
        end
        @(negedge clk);
        checks++;
        if ({bus.LS, bus.RS, bus.busy, bus.done} !== 4'b1100) begin
            errors++;
            $display("FAIL %s_after: got %b want 1100", name, {bus.LS, bus.RS, bus.busy, bus.done});
        end
    endtask

    // start held high, dwell=1: period of 5 with one idle cycle per crossing.
    task automatic test_back_to_back();
        bus.start   = 1'b1;
        bus.dir     = 1'b1;
        bus.backout = 1'b0;
        bus.dwell   = DWELL_W'(1);
        @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            int idx;
            logic [3:0] want;
            idx  = (i % 5) + 1;
            want = (idx <= 4) ? {exp_sns(idx, 1, 1'b1, 1'b0), 2'b10} : 4'b1101;
            checks++;
            if ({bus.LS, bus.RS, bus.busy, bus.done} !== want) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got %b want %b", i + 1,
                         {bus.LS, bus.RS, bus.busy, bus.done}, want);
            end
            if (i == 49) bus.start = 1'b0;
            @(negedge clk);
        end
        mdl_right += 10;
        checks++;
        if (bus.right_count !== CNT_W'(mdl_right)) begin
            errors++;
            $display("FAIL b2b_right_count: got %0d want %0d", bus.right_count, mdl_right % 256);
        end
        checks++;
        if ({bus.LS, bus.RS, bus.busy, bus.done} !== 4'b1100) begin
            errors++;
            $display("FAIL b2b_idle: got %b want 1100", {bus.LS, bus.RS, bus.busy, bus.done});
        end
    endtask

    // Reset in the middle of BOTH clears everything at once, no done pulse.
    task automatic test_reset_mid();
        bus.start   = 1'b1;
        bus.dir     = 1'b1;
        bus.backout = 1'b0;
        bus.dwell   = DWELL_W'(5);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if ({bus.LS, bus.RS, bus.busy} !== 3'b001) begin
            errors++;
            $display("FAIL mid_in_both: got %b want 001", {bus.LS, bus.RS, bus.busy});
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.LS, bus.RS, bus.busy, bus.done} !== 4'b1100) begin
            errors++;
            $display("FAIL mid_reset_async: got %b want 1100", {bus.LS, bus.RS, bus.busy, bus.done});
        end
        checks++;
        if ({bus.right_count, bus.left_count} !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset_counts: got %h want 0000", {bus.right_count, bus.left_count});
        end
        @(negedge clk);
        reset     = 1'b0;
        mdl_right = 0;
        mdl_left  = 0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (bus.done !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_done_%0d: got %b want 0", i, bus.done);
            end
            @(negedge clk);
        end
    endtask

    // 256 right crossings from zero: count reads 255 then wraps to 0.
    task automatic test_wrap();
        int n;
        reset = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        mdl_right   = 0;
        mdl_left    = 0;
        n           = 0;
        bus.start   = 1'b1;
        bus.dir     = 1'b1;
        bus.backout = 1'b0;
        bus.dwell   = DWELL_W'(1);
        for (int cyc = 0; cyc < 2000 && n < 256; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                n++;
                if (n == 255) begin
                    checks++;
                    if (bus.right_count !== 8'd255) begin
                        errors++;
                        $display("FAIL wrap_255: got %0d want 255", bus.right_count);
                    end
                end
                if (n == 256) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL wrap_done_pulses: got %0d want 256", n);
        end
        checks++;
        if ({bus.right_count, bus.left_count} !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_zero: got %h want 0000", {bus.right_count, bus.left_count});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_crossing("right_d3", 1'b1, 1'b0, 3, 1'b0);
        test_single_crossing("left_d0", 1'b0, 1'b0, 0, 1'b0);
        test_single_crossing("backout_d2", 1'b1, 1'b1, 2, 1'b0);
        test_single_crossing("backout_left_d1", 1'b0, 1'b1, 1, 1'b0);
        test_back_to_back();
        test_reset_mid();
        test_single_crossing("after_reset_d2", 1'b1, 1'b0, 2, 1'b0);
        test_single_crossing("latched_d4", 1'b1, 1'b0, 4, 1'b1);
        test_single_crossing("latched_left_d2", 1'b0, 1'b0, 2, 1'b1);
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach its summary within the time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/turkey_sensor_emulator.md
Name: turkey_sensor_emulator

Overview:
Generates the two light-sensor waveforms (LS, RS) of a turkey walking through the gate, so the crossing-detection state machine can be exercised in simulation and on the board without physical sensors. A single command starts one crossing: left-to-right, right-to-left, or a back-out that enters and retreats. Sensor encoding: 1 = beam clear, 0 = beam blocked, and idle is LS=RS=1. The block sits between the command/button logic and the detector's LS/RS inputs.

Parameters:
DWELL_W, 16, width of the per-phase dwell count
CNT_W, 8, width of each completed-crossing counter

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  request one crossing; sampled only while not busy
dir  input  1  1 = left-to-right (detector counts TurkeyRight), 0 = right-to-left
backout  input  1  1 = enter from the dir side, then retreat; the detector must not count it
dwell  input  DWELL_W  cycles each sensor phase is held; 0 is treated as 1
LS  output  1  emulated left sensor, driven from a flop
RS  output  1  emulated right sensor, driven from a flop
busy  output  1  high while a crossing is in progress
done  output  1  single-cycle pulse when a crossing finishes
right_count  output  CNT_W  number of completed full left-to-right crossings, wraps
left_count  output  CNT_W  number of completed full right-to-left crossings, wraps

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on the port reset.
- Reset values: state IDLE; LS=1, RS=1; busy=0; done=0; both counts 0. The value applies immediately on assertion, including mid-crossing.
- Effective dwell: D = max(dwell,1). D, dir and backout are latched on the cycle start is accepted. Later changes to these inputs do not affect the crossing in progress.
- States: IDLE, ENTER, BOTH, EXIT, GAP.
- Sensor patterns (LS,RS), dir=1:
  - ENTER = 01
  - BOTH = 00
  - EXIT = 10
  - GAP = 11
- Sensor patterns, dir=0: LS and RS are swapped (ENTER=10, BOTH=00, EXIT=01, GAP=11).
- IDLE drives 11.
- Transitions:
  - IDLE: start=1 -> ENTER at the next edge.
  - ENTER: after D cycles -> BOTH, or -> GAP if backout=1.
  - BOTH: after D cycles -> EXIT.
  - EXIT: after D cycles -> GAP.
  - GAP: after D cycles -> IDLE.
- Phase timing: each non-IDLE state holds exactly D cycles. A down-counter is loaded with D-1 on entry and the state advances when it reaches 0.
- LS/RS registering: the outputs are registered from next-state, so the new pattern appears in the same cycle the state register changes. No combinational glitches are allowed.
- Latency, full crossing: start is accepted at edge k. The ENTER pattern is visible from cycle k+1. busy=1 for 4D cycles. done=1 in cycle k+4D+1, with state IDLE and LS=RS=1.
- Latency, back-out: busy for 2D cycles; done in cycle k+2D+1.
- Counters: on done, right_count increments if the latched dir=1 and backout=0; left_count increments if dir=0 and backout=0. Back-outs never increment either count. Counts wrap modulo 2^CNT_W.
- start while busy: ignored, not queued.
- start in the done cycle: accepted, since state is IDLE. This gives back-to-back crossings with a single IDLE cycle (LS=RS=1) between them.
- Reset asserted mid-crossing: sensors return to 11 immediately; done is not pulsed; counts clear.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE, ST_ENTER, ST_BOTH, ST_EXIT, ST_GAP (one-hot, 5 bits, matching the one-hot style used by the detector);
  - sensor pattern constants SNS_CLEAR=2'b11, SNS_BOTH=2'b00;
  - DIR_RIGHT=1'b1.
- Sub-module phase_timer:
  - loadable DWELL_W down-counter;
  - inputs load and load_val;
  - output expire, asserted when the count is 0.
- Top level: FSM, output flops and the two counters.

Test Plan:
- Reset, then start=1, dir=1, backout=0, dwell=3 -> (LS,RS) = 01 for 3 cycles, 00 for 3, 10 for 3, 11 for 3. Then done in cycle 13 after accept. right_count=1, left_count=0. A detector instance pulses TurkeyRight exactly once.
- dir=0, dwell=0 -> patterns 10, 00, 01, 11 for 1 cycle each. done 5 cycles after accept. left_count=1 and the detector pulses TurkeyLeft once.
- backout=1, dir=1, dwell=2 -> 01 for 2 cycles, 11 for 2, done after 5 cycles. Both counts unchanged and the detector does not pulse.
- start held high continuously, dwell=1, dir=1 -> crossings repeat with one IDLE cycle between them. After 10 done pulses, right_count=10. A start pulse mid-crossing does not restart or extend the crossing.
- Assert reset during BOTH, dwell=5 -> LS=RS=1 in the same cycle, busy=0, no done pulse, counts 0. A fresh start afterwards behaves normally.
- Change dir and dwell one cycle after start is accepted -> the in-flight crossing keeps its latched values. 256 full right crossings with CNT_W=8 -> right_count wraps to 0.
